// File: rtl/wb_mem_bist.sv
// wb_mem_bist: pipelined Wishbone memory BIST, writes seed^k to NUM_WORDS words then reads back and compares.
// Define WB_MEM_BIST_TIMEOUT_EN to add a 256-cycle no-progress watchdog.
module wb_mem_bist #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NUM_WORDS  = 16
) (
  input  logic                    i_wb_clk,
  input  logic                    i_wb_rst,
  output logic                    o_wb_cyc,
  output logic                    o_wb_stb,
  output logic                    o_wb_we,
  output logic [DATA_WIDTH/8-1:0] o_wb_sel,
  output logic [ADDR_WIDTH-1:0]   o_wb_addr,
  output logic [DATA_WIDTH-1:0]   o_wb_data,
  input  logic [DATA_WIDTH-1:0]   i_wb_data,
  input  logic                    i_wb_ack,
  input  logic                    i_wb_stall,
  input  logic                    i_start,
  input  logic [DATA_WIDTH-1:0]   i_seed,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_pass,
  output logic [15:0]             o_err_count,
  output logic [ADDR_WIDTH-1:0]   o_fail_addr,
  output logic [DATA_WIDTH-1:0]   o_fail_data
);
  localparam int BYTES = DATA_WIDTH / 8;
  localparam logic [2:0] S_IDLE = 3'd0, S_WR_REQ = 3'd1, S_WR_ACK = 3'd2,
                         S_RD_REQ = 3'd3, S_RD_ACK = 3'd4, S_DONE = 3'd5;
  logic [2:0]            r_state;
  logic [15:0]           r_idx;
  logic [DATA_WIDTH-1:0] r_seed;
  logic [15:0]           w_idx_inc;
  logic [ADDR_WIDTH-1:0] w_addr_inc;
  logic [DATA_WIDTH-1:0] w_data_inc;
  logic                  w_last;
  logic [15:0]           w_err_inc;
  logic [15:0]           w_err_rd;
  assign o_wb_sel   = '1;
  assign w_idx_inc  = r_idx + 16'd1;
  assign w_addr_inc = BASE_ADDR + ADDR_WIDTH'(32'(w_idx_inc) * BYTES);
  assign w_data_inc = r_seed ^ DATA_WIDTH'(w_idx_inc);
  assign w_last     = r_idx == 16'(NUM_WORDS - 1);
  assign w_err_inc  = o_err_count + 16'(o_err_count != 16'hFFFF);
  // o_wb_data keeps the expected pattern during reads, so it doubles as the compare reference
  assign w_err_rd   = (i_wb_data != o_wb_data) ? w_err_inc : o_err_count;
`ifdef WB_MEM_BIST_TIMEOUT_EN
  logic [7:0] r_wdog;
  logic       w_prog;
  assign w_prog = ((r_state == S_WR_REQ || r_state == S_RD_REQ) && !i_wb_stall) ||
                  ((r_state == S_WR_ACK || r_state == S_RD_ACK) && i_wb_ack);
`endif
  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_seed      <= '0;
      o_wb_cyc    <= 1'b0;
      o_wb_stb    <= 1'b0;
      o_wb_we     <= 1'b0;
      o_wb_addr   <= '0;
      o_wb_data   <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pass      <= 1'b0;
      o_err_count <= '0;
      o_fail_addr <= '0;
      o_fail_data <= '0;
`ifdef WB_MEM_BIST_TIMEOUT_EN
      r_wdog      <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (i_start) begin
          r_state     <= S_WR_REQ;
          r_idx       <= '0;
          r_seed      <= i_seed;
          o_wb_cyc    <= 1'b1;
          o_wb_stb    <= 1'b1;
          o_wb_we     <= 1'b1;
          o_wb_addr   <= BASE_ADDR;
          o_wb_data   <= i_seed;
          o_busy      <= 1'b1;
          o_done      <= 1'b0;
          o_pass      <= 1'b0;
          o_err_count <= '0;
          o_fail_addr <= '0;
          o_fail_data <= '0;
        end
        S_WR_REQ, S_RD_REQ: if (!i_wb_stall) begin
          r_state  <= (r_state == S_WR_REQ) ? S_WR_ACK : S_RD_ACK;
          o_wb_stb <= 1'b0;
        end
        S_WR_ACK: if (i_wb_ack) begin
          r_state   <= w_last ? S_RD_REQ : S_WR_REQ;
          r_idx     <= w_last ? '0 : w_idx_inc;
          o_wb_stb  <= 1'b1;
          o_wb_we   <= !w_last;
          o_wb_addr <= w_last ? BASE_ADDR : w_addr_inc;
          o_wb_data <= w_last ? r_seed : w_data_inc;
        end
        S_RD_ACK: if (i_wb_ack) begin
          o_err_count <= w_err_rd;
          if (i_wb_data != o_wb_data && o_err_count == '0) begin
            o_fail_addr <= o_wb_addr;
            o_fail_data <= i_wb_data;
          end
          r_state   <= w_last ? S_DONE : S_RD_REQ;
          r_idx     <= w_idx_inc;
          o_wb_cyc  <= !w_last;
          o_wb_stb  <= !w_last;
          o_wb_addr <= w_addr_inc;
          o_wb_data <= w_data_inc;
          o_busy    <= !w_last;
          o_done    <= w_last;
          o_pass    <= w_last && w_err_rd == '0;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef WB_MEM_BIST_TIMEOUT_EN
      r_wdog <= (o_busy && !w_prog) ? r_wdog + 8'd1 : '0;
      if (o_busy && !w_prog && r_wdog == 8'hFF) begin
        r_state     <= S_DONE;
        o_wb_cyc    <= 1'b0;
        o_wb_stb    <= 1'b0;
        o_wb_we     <= 1'b0;
        o_busy      <= 1'b0;
        o_done      <= 1'b1;
        o_pass      <= 1'b0;
        o_err_count <= w_err_inc;
        o_fail_addr <= o_wb_addr;
        o_fail_data <= '0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_wb_mem_bist.sv
// tb_wb_mem_bist: scoreboard bench for wb_mem_bist (NUM_WORDS=4, BASE_ADDR=0x100) with a small Wishbone slave model.
module tb_wb_mem_bist;
  typedef struct { logic we; logic [31:0] a; logic [31:0] d; } req_t;
  typedef struct { logic [15:0] ec; logic [31:0] fa; logic [31:0] fd; logic p; } stat_t;
  logic clk = 0, rst = 1, start = 0;
  logic [31:0] seed = 0;
  logic cyc, stb, we, ack, stall, busy, done, pass;
  logic [3:0] sel;
  logic [31:0] addr, wdata, rdata, fail_addr, fail_data;
  logic [15:0] err_count;
  logic [31:0] mem [4];
  logic corrupt = 0, no_ack = 0, stall_en = 0;
  int stall_cnt = 0, acc104 = 0, total = 0, bad = 0;
  logic prev_done = 0;
  req_t q_req[$];
  stat_t q_stat[$];
  always #5 clk = ~clk;
  wb_mem_bist #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BASE_ADDR(32'h100), .NUM_WORDS(4)) dut (
    .i_wb_clk(clk), .i_wb_rst(rst), .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_we(we),
    .o_wb_sel(sel), .o_wb_addr(addr), .o_wb_data(wdata), .i_wb_data(rdata),
    .i_wb_ack(ack), .i_wb_stall(stall), .i_start(start), .i_seed(seed),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err_count),
    .o_fail_addr(fail_addr), .o_fail_data(fail_data));
  assign stall = stall_en && cyc && stb && we && addr == 32'h104 && stall_cnt < 5;
  always @(posedge clk) begin
    logic [1:0] ix;
    ix = 2'((addr - 32'h100) >> 2);
    ack <= cyc && stb && !stall && !no_ack;
    if (cyc && stb && !stall && we) mem[ix] <= wdata;
    rdata <= (corrupt && addr == 32'h108) ? 32'hDEADBEEF : mem[ix];
    stall_cnt <= !stall_en ? 0 : stall ? stall_cnt + 1 : stall_cnt;
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    req_t e;
    stat_t s;
    if (stall) begin
      chk("stall_addr", 64'(addr), 64'h104);
      chk("stall_data", 64'(wdata), 64'hA5A5A5A4);
    end
    if (cyc && stb && !stall) begin
      if (we && addr == 32'h104) acc104++;
      if (q_req.size() == 0) chk("req_unexpected", 1, 0);
      else begin
        e = q_req.pop_front();
        chk("req_we", 64'(we), 64'(e.we));
        chk("req_addr", 64'(addr), 64'(e.a));
        if (e.we) chk("req_data", 64'(wdata), 64'(e.d));
      end
    end
    if (done && !prev_done) begin
      if (q_stat.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        s = q_stat.pop_front();
        chk("stat_err", 64'(err_count), 64'(s.ec));
        chk("stat_fail_addr", 64'(fail_addr), 64'(s.fa));
        chk("stat_fail_data", 64'(fail_data), 64'(s.fd));
        chk("stat_pass", 64'(pass), 64'(s.p));
      end
    end
    prev_done = done;
  end
  task automatic push_run(input logic [31:0] sd, input int nwr, input int nrd, input stat_t s);
    for (int k = 0; k < nwr; k++) q_req.push_back('{1'b1, 32'h100 + 32'(k * 4), sd ^ 32'(k)});
    for (int k = 0; k < nrd; k++) q_req.push_back('{1'b0, 32'h100 + 32'(k * 4), sd ^ 32'(k)});
    q_stat.push_back(s);
  endtask
  task automatic do_start(input logic [31:0] sd);
    @(negedge clk);
    seed = sd;
    start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_ctrl", 64'({cyc, stb, we, busy, done, pass}), 0);
    chk("rst_err", 64'(err_count), 0);
    chk("rst_fail", {fail_addr, fail_data}, 0);
    chk("rst_bus", {addr, wdata}, 0);
    @(negedge clk);
    rst = 0;
    q_req.delete();
    q_stat.delete();
  endtask
  initial begin
    int n, a0;
    do_reset();
    push_run(32'hA5A5A5A5, 4, 4, '{16'd0, 32'h0, 32'h0, 1'b1});
    do_start(32'hA5A5A5A5);
    chk("busy_after_start", 64'(busy), 1);
    wait_done(n);
    chk("done_cycle", 64'(n + 1), 17);
    chk("cyc_done", 64'(cyc), 0);
    corrupt = 1;
    push_run(32'hA5A5A5A5, 4, 4, '{16'd1, 32'h108, 32'hDEADBEEF, 1'b0});
    do_start(32'hA5A5A5A5);
    wait_done(n);
    corrupt = 0;
    stall_en = 1;
    a0 = acc104;
    push_run(32'hA5A5A5A5, 4, 4, '{16'd0, 32'h0, 32'h0, 1'b1});
    do_start(32'hA5A5A5A5);
    wait_done(n);
    chk("stall_accepts", 64'(acc104 - a0), 1);
    chk("stall_cycles", 64'(stall_cnt), 5);
    stall_en = 0;
    corrupt = 1;
    push_run(32'hA5A5A5A5, 4, 4, '{16'd1, 32'h108, 32'hDEADBEEF, 1'b0});
    do_start(32'hA5A5A5A5);
    repeat (13) @(posedge clk);
    @(negedge clk);
    seed = 32'h12345678;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    chk("busy_start_busy", 64'(busy), 1);
    chk("err_not_cleared", 64'(err_count), 1);
    wait_done(n);
    corrupt = 0;
    push_run(32'h0F0F0000, 4, 4, '{16'd0, 32'h0, 32'h0, 1'b1});
    do_start(32'h0F0F0000);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc && !stb && !we && busy) && n < 40);
    chk("found_rd_ack", 64'(n < 40), 1);
    rst = 1;
    @(posedge clk);
    #1;
    chk("rst_mid_ctrl", 64'({cyc, stb, we, busy, done, pass}), 0);
    chk("rst_mid_vals", {16'(err_count), fail_addr, 16'(fail_data)}, 0);
    @(negedge clk);
    rst = 0;
    q_req.delete();
    q_stat.delete();
    repeat (3) @(posedge clk);
    #1 chk("idle_after_rst", 64'({cyc, busy, done}), 0);
    push_run(32'h13572468, 4, 4, '{16'd0, 32'h0, 32'h0, 1'b1});
    do_start(32'h13572468);
    wait_done(n);
    chk("clean_pass", 64'(pass), 1);
`ifdef WB_MEM_BIST_TIMEOUT_EN
    no_ack = 1;
    push_run(32'hA5A5A5A5, 1, 0, '{16'd1, 32'h100, 32'h0, 1'b0});
    do_start(32'hA5A5A5A5);
    wait_done(n);
    chk("to_cycles", 64'(n), 257);
    chk("to_cyc", 64'(cyc), 0);
    no_ack = 0;
    do_reset();
`endif
    repeat (2) @(posedge clk);
    chk("req_queue_empty", 64'(q_req.size()), 0);
    chk("stat_queue_empty", 64'(q_stat.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_mem_bist.md
WB_MEM_BIST -- requirements
Module: wb_mem_bist

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning Wishbone data width in bits (multiple of 8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, meaning Wishbone byte-address width.
REQ-003 SHALL have parameter BASE_ADDR, default 0, meaning byte address of the first word tested.
REQ-004 SHALL have parameter NUM_WORDS, default 16, meaning number of words tested (1..2^16).
REQ-005 SHALL have port i_wb_clk  input  1  meaning the single clock; all logic is on its rising edge.
REQ-006 SHALL have port i_wb_rst  input  1  meaning the reset, which is synchronous and active-high.
REQ-007 SHALL have ports o_wb_cyc/o_wb_stb/o_wb_we (output, 1 each), meaning the pipelined Wishbone master controls.
REQ-008 SHALL have ports o_wb_sel (output, DATA_WIDTH/8), o_wb_addr (output, ADDR_WIDTH) and o_wb_data (output, DATA_WIDTH), meaning the master request fields.
REQ-009 SHALL have ports i_wb_data (input, DATA_WIDTH), i_wb_ack (input, 1) and i_wb_stall (input, 1), meaning the slave response.
REQ-010 SHALL have ports i_start (input, 1), meaning begin a run, and i_seed (input, DATA_WIDTH), meaning pattern seed, sampled when i_start is accepted.
REQ-011 SHALL have status outputs o_busy (1), o_done (1), o_pass (1) and o_err_count (16).
REQ-012 SHALL have status outputs o_fail_addr (ADDR_WIDTH) and o_fail_data (DATA_WIDTH), meaning the first mismatching address and the read value at that address.

Function
REQ-013 SHALL implement the states IDLE, WR_REQ, WR_ACK, RD_REQ, RD_ACK and DONE.
REQ-014 SHALL accept i_start only in IDLE or DONE: clear the counters and error state, latch i_seed, set index=0 and enter WR_REQ on the next cycle; i_start in any other state is ignored.
REQ-015 SHALL drive, for word index k, address BASE_ADDR + k*(DATA_WIDTH/8) (modulo 2^ADDR_WIDTH, wrapping) and pattern i_seed XOR k (k zero-extended), with o_wb_sel all ones.
REQ-016 SHALL, in WR_REQ/RD_REQ, hold cyc=stb=1 with stable addr/we/data; the request is accepted on the cycle stb=1 and i_wb_stall=0, after which stb drops and the state goes to WR_ACK/RD_ACK.
REQ-017 SHALL keep at most one transaction outstanding; cyc stays high from the first request until the ack of the final read, and stb=0 in the *_ACK states.
REQ-018 SHALL ignore i_wb_ack outside the *_ACK states.
REQ-019 SHALL, on ack in WR_ACK, increment k and return to WR_REQ, or, if k=NUM_WORDS-1, set k=0 and go to RD_REQ.
REQ-020 SHALL, on ack in RD_ACK, compare i_wb_data with the pattern; on mismatch, increment o_err_count (saturating at 0xFFFF), and capture o_fail_addr/o_fail_data only if it is the first error of the run.
REQ-021 SHALL, after the final read ack, deassert cyc and enter DONE.
REQ-022 SHALL hold o_busy=1 in every state except IDLE and DONE.
REQ-023 SHALL hold o_done=1 in DONE; o_pass SHALL equal (o_err_count==0) while in DONE and 0 otherwise.
REQ-024 SHALL make all outputs registered; a start-to-done run with zero stall and one-cycle ack SHALL take 4*NUM_WORDS+1 cycles.

Reset
REQ-025 SHALL, while i_wb_rst=1 at a clock edge, enter IDLE and drive cyc, stb, we, o_busy, o_done, o_pass, o_err_count, o_fail_addr, o_fail_data, o_wb_addr and o_wb_data to 0.
REQ-026 SHALL, on reset mid-transaction, drop cyc on the following edge; no ack arriving afterwards is counted.
REQ-027 SHALL give i_wb_rst priority over i_start in the same cycle.

Configuration
REQ-028 SHALL, with WB_MEM_BIST_TIMEOUT_EN defined, count cycles spent in any *_ACK or *_REQ state without progress; on reaching 256, drop cyc, increment o_err_count, set o_fail_addr to the current address and o_fail_data to 0, and enter DONE.
REQ-029 SHALL, without WB_MEM_BIST_TIMEOUT_EN, omit the watchdog logic entirely and wait indefinitely for stall release and ack.

Verification
REQ-030 SHALL verify a run with NUM_WORDS=4, BASE_ADDR=0x100, seed 0xA5A5A5A5 and an ideal slave -> writes to 0x100/0x104/0x108/0x10C of 0xA5A5A5A5/A4/A7/A6, then matching reads, o_pass=1 and o_done at cycle 17.
REQ-031 SHALL verify a read-back corruption in which the slave returns 0xDEADBEEF for 0x108 only -> o_err_count=1, o_fail_addr=0x108, o_fail_data=0xDEADBEEF, o_pass=0.
REQ-032 SHALL verify i_wb_stall held for 5 cycles on the second write -> addr/data stable throughout, exactly one accept, and the run otherwise passes.
REQ-033 SHALL verify i_wb_rst asserted in RD_ACK -> next cycle IDLE, all outputs 0, and a later i_start gives a clean pass.
REQ-034 SHALL verify, with WB_MEM_BIST_TIMEOUT_EN defined and the slave never acking the first write -> DONE after 256 cycles, o_err_count=1, o_fail_addr=BASE_ADDR, cyc=0.
REQ-035 SHALL verify i_start pulsed while busy -> ignored, with no restart and no counter clear.
